// File: rtl/clzo_pkg.sv
// Shared defaults, op encoding and width helper for the CLZ/CLO pipeline.
package clzo_pkg;

  localparam int CLZ_DATA_W  = 32;
  localparam int CLZ_GROUP_W = 4;

  typedef enum logic {
    OP_CLZ = 1'b0,
    OP_CLO = 1'b1
  } clzo_op_e;

  // Count field must hold 0..DATA_W inclusive, hence the extra bit.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/clzo_group.sv
// Per-group leading-zero detector: zero flag plus count of leading zeros
// inside one GROUP_W-bit slice (MSB of the slice is position 0).
module clzo_group
  import clzo_pkg::*;
#(
  parameter int GROUP_W = CLZ_GROUP_W,
  localparam int LC_W   = $clog2(GROUP_W)
) (
  input  logic [GROUP_W-1:0] grp_bits,
  output logic               zero,
  output logic [LC_W-1:0]    lc
);

  // Priority encode from the MSB; later (higher) set bits override lower ones.
  always_comb begin
    zero = ~|grp_bits;
    lc   = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      if (grp_bits[i]) lc = LC_W'(GROUP_W - 1 - i);
    end
  end

endmodule

// File: rtl/clzo_pipe.sv
// Two-stage pipelined leading-zero / leading-one counter with valid/ready
// handshake, flush and a pass-through destination tag.
module clzo_pipe
  import clzo_pkg::*;
#(
  parameter int DATA_W  = CLZ_DATA_W,
  parameter int GROUP_W = CLZ_GROUP_W,
  parameter int TAG_W   = 5,
  localparam int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_clo,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_full,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NG   = DATA_W / GROUP_W;
  localparam int LC_W = $clog2(GROUP_W);

  logic [DATA_W-1:0]        operand;
  logic [NG-1:0]            grp_zero;
  logic [NG-1:0][LC_W-1:0]  grp_lc;

  logic                     s1_valid_q, s1_valid_d;
  logic [NG-1:0]            s1_zero_q, s1_zero_d;
  logic [NG-1:0][LC_W-1:0]  s1_lc_q, s1_lc_d;
  logic [TAG_W-1:0]         s1_tag_q, s1_tag_d;

  logic                     s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0]         s2_count_q, s2_count_d;
  logic                     s2_full_q, s2_full_d;
  logic [TAG_W-1:0]         s2_tag_q, s2_tag_d;

  logic                     s2_adv, s1_moves, accept;
  logic [CNT_W-1:0]         merge_count;
  logic                     merge_full;

  // CLO reuses the CLZ datapath on the inverted operand.
  assign operand = (in_clo == OP_CLO) ? ~in_data : in_data;

  // Group 0 is the most significant slice of the operand.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    clzo_group #(.GROUP_W(GROUP_W)) u_grp (
      .grp_bits (operand[DATA_W-1-g*GROUP_W -: GROUP_W]),
      .zero     (grp_zero[g]),
      .lc       (grp_lc[g])
    );
  end

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_moves = s1_valid_q & s2_adv;
  assign in_ready = ~s1_valid_q | s1_moves;
  assign accept   = in_valid & in_ready & ~flush;

  // Stage-1 next state: load group results on accept, empty when moved on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_zero_d  = s1_zero_q;
    s1_lc_d    = s1_lc_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_zero_d  = grp_zero;
      s1_lc_d    = grp_lc;
      s1_tag_d   = in_tag;
    end else if (s1_moves) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage-2 merge: first non-zero group wins; all-zero means full count.
  always_comb begin
    merge_count = CNT_W'(DATA_W);
    merge_full  = 1'b1;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!s1_zero_q[g]) begin
        merge_count = CNT_W'(g * GROUP_W) + CNT_W'(s1_lc_q[g]);
        merge_full  = 1'b0;
      end
    end
  end

  // Stage-2 next state: only changes when the consumer side can advance.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_count_d = s2_count_q;
    s2_full_d  = s2_full_q;
    s2_tag_d   = s2_tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_count_d = merge_count;
        s2_full_d  = merge_full;
        s2_tag_d   = s1_tag_q;
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= '0;
      s1_lc_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_count_q <= '0;
      s2_full_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_zero_q  <= s1_zero_d;
      s1_lc_q    <= s1_lc_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_count_q <= s2_count_d;
      s2_full_q  <= s2_full_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_count = s2_count_q;
  assign out_full  = s2_full_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_clzo_pipe.sv
// Directed and randomised checks of clzo_pipe at 32/4 and 64/8 geometries.
module tb_clzo_pipe;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_clo;
  logic [4:0]  in_tag;
  logic        out_ready;
  logic        use64;

  logic        in_ready32, out_valid32, out_full32;
  logic [5:0]  out_count32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_full64;
  logic [6:0]  out_count64;
  logic [4:0]  out_tag64;

  logic        obs_ready, obs_valid, obs_full;
  logic [6:0]  obs_count;
  logic [4:0]  obs_tag;

  int errors = 0;
  int checks = 0;

  clzo_pipe #(.DATA_W(32), .GROUP_W(4), .TAG_W(5)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data[31:0]),
    .in_clo(in_clo), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_count(out_count32),
    .out_full(out_full32), .out_tag(out_tag32)
  );

  clzo_pipe #(.DATA_W(64), .GROUP_W(8), .TAG_W(5)) dut64 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data),
    .in_clo(in_clo), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_count(out_count64),
    .out_full(out_full64), .out_tag(out_tag64)
  );

  // Both instances see identical control, so one is observed at a time.
  assign obs_ready = use64 ? in_ready64  : in_ready32;
  assign obs_valid = use64 ? out_valid64 : out_valid32;
  assign obs_full  = use64 ? out_full64  : out_full32;
  assign obs_count = use64 ? out_count64 : 7'(out_count32);
  assign obs_tag   = use64 ? out_tag64   : out_tag32;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Reference leading-zero count, scanning bit by bit from the MSB.
  function automatic int refClz(input logic [63:0] v, input int width);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n++;
    end
    return n;
  endfunction

  // Offer one operand with out_ready high and check latency and result.
  task automatic applyStimulus(input logic [63:0] data, input logic clo,
                               input logic [4:0] tag, input int expCount,
                               input logic expFull);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = data;
    in_clo    = clo;
    in_tag    = tag;
    #1;
    checkOutput("in_ready", 64'(obs_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("lat_edge1", 64'(obs_valid), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("lat_edge2", 64'(obs_valid), 64'd1);
    checkOutput("count", 64'(obs_count), 64'(expCount));
    checkOutput("full", 64'(obs_full), 64'(expFull));
    checkOutput("tag", 64'(obs_tag), 64'(tag));
  endtask

  logic [63:0] bpData [4];
  logic        bpClo  [4];
  int          bpExp  [4];
  logic [12:0] expQ [$];

  initial begin
    int sent, rcvd, target;
    logic taken;
    logic [6:0] holdCount;
    logic [4:0] holdTag;
    logic [12:0] e;
    logic [63:0] rnd;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_clo = 1'b0; in_tag = '0; out_ready = 1'b0; use64 = 1'b0;
    #12;
    checkOutput("rst_valid", 64'(obs_valid), 64'd0);
    checkOutput("rst_count", 64'(obs_count), 64'd0);
    checkOutput("rst_full", 64'(obs_full), 64'd0);
    checkOutput("rst_tag", 64'(obs_tag), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("rst_ready", 64'(obs_ready), 64'd1);

    applyStimulus(64'h0001_0000, 1'b0, 5'd1, 15, 1'b0);
    applyStimulus(64'h8000_0000, 1'b0, 5'd2, 0, 1'b0);
    applyStimulus(64'h0000_0001, 1'b0, 5'd3, 31, 1'b0);
    applyStimulus(64'h0000_0000, 1'b0, 5'd4, 32, 1'b1);
    applyStimulus(64'hF000_0000, 1'b1, 5'd5, 4, 1'b0);
    applyStimulus(64'hFFFF_FFFF, 1'b1, 5'd6, 32, 1'b1);
    applyStimulus(64'h7FFF_FFFF, 1'b1, 5'd7, 0, 1'b0);

    // Backpressure: four operands, consumer stalled for the first four cycles.
    bpData[0] = 64'h0001_0000; bpClo[0] = 1'b0; bpExp[0] = 15;
    bpData[1] = 64'h0000_00FF; bpClo[1] = 1'b0; bpExp[1] = 24;
    bpData[2] = 64'hFF00_0000; bpClo[2] = 1'b1; bpExp[2] = 8;
    bpData[3] = 64'h0000_0000; bpClo[3] = 1'b1; bpExp[3] = 0;
    sent = 0; rcvd = 0; holdCount = '0; holdTag = '0;
    for (int cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_data = bpData[sent];
        in_clo  = bpClo[sent];
        in_tag  = 5'(sent + 1);
      end
      #1;
      if (cyc == 2) begin
        holdCount = obs_count;
        holdTag   = obs_tag;
      end
      if (cyc == 3) begin
        checkOutput("bp_accepted", 64'(sent), 64'd2);
        checkOutput("bp_in_ready", 64'(obs_ready), 64'd0);
        checkOutput("bp_hold_count", 64'(obs_count), 64'(holdCount));
        checkOutput("bp_hold_tag", 64'(obs_tag), 64'(holdTag));
      end
      if (obs_valid && out_ready) begin
        checkOutput("bp_tag", 64'(obs_tag), 64'(rcvd + 1));
        checkOutput("bp_count", 64'(obs_count), 64'(bpExp[rcvd]));
        rcvd++;
      end
      if (in_valid && obs_ready) sent++;
    end
    checkOutput("bp_received", 64'(rcvd), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;

    // Flush with both stages occupied and a new operand on offer.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0000_00F0; in_clo = 1'b0; in_tag = 5'd10;
    @(negedge clk);
    in_tag = 5'd11;
    @(negedge clk);
    #1;
    checkOutput("fl_pre_valid", 64'(obs_valid), 64'd1);
    flush = 1'b1; in_tag = 5'd12; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("fl_valid", 64'(obs_valid), 64'd0);
    checkOutput("fl_in_ready", 64'(obs_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("fl_empty", 64'(obs_valid), 64'd0);
    end

    // Asynchronous reset while both stages hold results.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0; in_clo = 1'b0; in_tag = 5'd20;
    @(negedge clk);
    in_data = 64'h0001_0000; in_tag = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("ar_pre_full", 64'(obs_full), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(obs_valid), 64'd0);
    checkOutput("ar_count", 64'(obs_count), 64'd0);
    checkOutput("ar_full", 64'(obs_full), 64'd0);
    checkOutput("ar_tag", 64'(obs_tag), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(64'h0000_0400, 1'b0, 5'd22, 21, 1'b0);

    // Wide geometry, directed.
    use64 = 1'b1;
    applyStimulus(64'h1, 1'b0, 5'd30, 63, 1'b0);
    applyStimulus(64'h0, 1'b0, 5'd31, 64, 1'b1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FF00, 1'b1, 5'd29, 56, 1'b0);

    // Wide geometry, random operands with random backpressure.
    @(negedge clk);
    in_valid = 1'b0;
    target = 1500; sent = 0; rcvd = 0; taken = 1'b0;
    for (int cyc = 0; cyc < 20000 && rcvd < target; cyc++) begin
      @(negedge clk);
      if (taken) in_valid = 1'b0;
      taken = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < target && $urandom_range(0, 3) != 0) begin
        rnd      = {$urandom(), $urandom()} >> $urandom_range(0, 64);
        in_clo   = 1'($urandom_range(0, 1));
        in_data  = in_clo ? ~rnd : rnd;
        in_tag   = 5'($urandom());
        in_valid = 1'b1;
      end
      #1;
      if (obs_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("rnd_unexpected", 64'(obs_tag), 64'h1F00);
        end else begin
          e = expQ.pop_front();
          checkOutput("rnd_count", 64'(obs_count), 64'(e[12:6]));
          checkOutput("rnd_full", 64'(obs_full), 64'(e[5]));
          checkOutput("rnd_tag", 64'(obs_tag), 64'(e[4:0]));
        end
        rcvd++;
      end
      if (in_valid && obs_ready) begin
        e[12:6] = 7'(refClz(in_clo ? ~in_data : in_data, 64));
        e[5]    = (e[12:6] == 7'd64);
        e[4:0]  = in_tag;
        expQ.push_back(e);
        sent++;
        taken = 1'b1;
      end
    end
    checkOutput("rnd_received", 64'(rcvd), 64'(target));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
